mem_arbiter: RTL and testbench

- Sequences a single shared backing memory port between the instruction-fetch requester and the data-memory (load/store) requester of the 5-stage RISC-V pipeline.
- Sits between the fetch/memory stages and a unified single-port RAM with a req/ack handshake.
- Produces stall indications so the hazard logic can freeze the F and M stages while an access is outstanding.

---
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every handshake/bus signal around the shared
// memory-port arbiter. The "slave" modport is the arbiter's own view (it
// serves the fetch and data requesters and drives the backing RAM port);
// the "master" modport is the surrounding pipeline + RAM environment.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    // Instruction-fetch requester
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ready;

    // Data (load/store) requester
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_ready;

    // Backing single-port memory
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    // Hazard-unit stall outputs and timeout error
    logic                  stall_f;
    logic                  stall_m;
    logic                  bus_err;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ready,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output stall_f, stall_m, bus_err
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ready,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  stall_f, stall_m, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing memory port between the instruction-fetch
// and data (load/store) requesters of the 5-stage pipeline.
//   - Data wins ties (the older instruction sits in M), but after STARVE_MAX
//     consecutive data grants with fetch waiting, fetch is forced through.
//   - Every access takes IDLE -> BUSY_x -> DONE, so the minimum is 3 cycles.
//   - stall_f / stall_m let the hazard logic freeze F and M while waiting.
// Optional feature: define ARB_TIMEOUT_EN to abort accesses whose mem_ack
// does not arrive within TIMEOUT cycles (bus_err pulse, NOP / zero data).
// Without it, BUSY waits indefinitely and bus_err is tied low.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 3
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 16
`endif
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic                  if_ready_q;
    logic                  d_ready_q;
    logic [SC_W-1:0]       starve_cnt;

    // Grant decision, only acted upon in IDLE.
    logic                  starve_ok;
    logic                  grant_d;
    logic                  grant_if;
    logic [SC_W-1:0]       starve_inc;

    assign starve_ok  = (starve_cnt < SC_W'(STARVE_MAX));
    assign grant_d    = bus.d_req & (~bus.if_req | starve_ok);
    assign grant_if   = bus.if_req & ~grant_d;
    assign starve_inc = (starve_cnt == SC_W'(STARVE_MAX)) ? starve_cnt
                                                          : starve_cnt + SC_W'(1);

    // Timeout machinery exists only when the feature is compiled in.
    logic timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int                    TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [DATA_WIDTH-1:0] NOP_INSN = DATA_WIDTH'(32'h0000_0013);

    logic [TMO_W-1:0] tmo_cnt;
    logic             bus_err_q;

    // Counts cycles spent in BUSY_x; restarts from zero for every access.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == BUSY_IF || state == BUSY_D) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // mem_req has been high for TIMEOUT cycles by the end of this cycle.
    assign timeout_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Arbitration FSM with all outputs registered.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data-path registers are reset too; the outputs must
            // read zero after reset, not whatever the last access left.
            state       <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            starve_cnt  <= '0;
`ifdef ARB_TIMEOUT_EN
            bus_err_q   <= 1'b0;
`endif
        end else begin
            // Completion and error strobes are single-cycle pulses.
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            bus_err_q  <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                        // Only consecutive data grants that keep fetch waiting count.
                        starve_cnt  <= bus.if_req ? starve_inc : '0;
                        state       <= BUSY_D;
                    end else if (grant_if) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        starve_cnt  <= '0;
                        state       <= BUSY_IF;
                    end
                end

                BUSY_IF, BUSY_D: begin
                    // mem_* stay frozen until the memory acknowledges.
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (state == BUSY_IF) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_ready_q <= 1'b1;
                        end else begin
                            // Stores leave the last load value in place.
                            if (!mem_we_q) begin
                                d_rdata_q <= bus.mem_rdata;
                            end
                            d_ready_q <= 1'b1;
                        end
                        state <= DONE;
                    end else if (timeout_hit) begin
                        mem_req_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                        bus_err_q <= 1'b1;
                        if (state == BUSY_IF) begin
                            // A NOP keeps the pipeline harmless after a lost fetch.
                            if_rdata_q <= NOP_INSN;
                            if_ready_q <= 1'b1;
                        end else begin
                            if (!mem_we_q) begin
                                d_rdata_q <= '0;
                            end
                            d_ready_q <= 1'b1;
                        end
`endif
                        state <= DONE;
                    end
                end

                DONE: begin
                    // The ready pulse is visible now; the requester updates
                    // its request before the next IDLE decision.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;

    // Stalls are combinational so the hazard unit releases F/M in the
    // same cycle the ready pulse arrives.
    assign bus.stall_f = bus.if_req & ~if_ready_q;
    assign bus.stall_m = bus.d_req & ~d_ready_q;

`ifdef ARB_TIMEOUT_EN
    assign bus.bus_err = bus_err_q;
`else
    assign bus.bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter. Each stimulus step pushes
// its hand-computed completion (port, read data, error flag) into a
// scoreboard queue; an independent monitor pops and compares on every
// if_ready / d_ready pulse. A behavioural RAM answers mem_req with a
// programmable ack delay. Cycle-level timing is checked inline.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .STARVE_MAX(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit            is_d;
        logic [DW-1:0] rdata;
        bit            err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_done(input bit is_d, input logic [DW-1:0] rdata, input bit err);
        sb_q.push_back('{is_d, rdata, err});
    endtask

    // Behavioural RAM: acknowledges ack_delay cycles after mem_req rises.
    logic [DW-1:0] mem_model [int];
    bit            ack_en    = 1'b1;
    int            ack_delay = 0;
    int            wait_cnt  = 0;

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b0 && ack_en) begin
                if (wait_cnt >= ack_delay) begin
                    if (bus.mem_we === 1'b1) begin
                        mem_model[int'(bus.mem_addr)] = bus.mem_wdata;
                    end
                    bus.mem_rdata = mem_model.exists(int'(bus.mem_addr))
                                  ? mem_model[int'(bus.mem_addr)] : 32'hBAD0_0BAD;
                    bus.mem_ack   = 1'b1;
                    wait_cnt      = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
                if (bus.mem_req !== 1'b1) wait_cnt = 0;
            end
        end
    end

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.if_ready === 1'b1 || bus.d_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", {bus.d_ready, bus.if_ready}, 2'b00);
            end else begin
                mon_e = sb_q.pop_front();
                check("ready_port", {bus.d_ready, bus.if_ready}, mon_e.is_d ? 2'b10 : 2'b01);
                if (mon_e.is_d) check("d_rdata", bus.d_rdata, mon_e.rdata);
                else            check("if_rdata", bus.if_rdata, mon_e.rdata);
                check("bus_err", bus.bus_err, mon_e.err);
            end
        end
    end

    task automatic do_fetch(input logic [AW-1:0] addr, input int budget);
        bit seen = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.if_ready === 1'b1) seen = 1'b1;
        end
        bus.if_req = 1'b0;
        check("fetch_completes", seen, 1);
    endtask

    task automatic do_data(input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int budget);
        bit seen = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.d_ready === 1'b1) seen = 1'b1;
        end
        bus.d_req = 1'b0;
        check("data_completes", seen, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},   bus.mem_req,   0);
        check({tag, "_mem_we"},    bus.mem_we,    0);
        check({tag, "_mem_addr"},  bus.mem_addr,  0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_if_rdata"},  bus.if_rdata,  0);
        check({tag, "_d_rdata"},   bus.d_rdata,   0);
        check({tag, "_if_ready"},  bus.if_ready,  0);
        check({tag, "_d_ready"},   bus.d_ready,   0);
        check({tag, "_bus_err"},   bus.bus_err,   0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;

        mem_model[12'h004] = 32'h0050_0093;
        mem_model[12'h008] = 32'h0010_0113;
        mem_model[12'h00C] = 32'h0020_0193;
        mem_model[12'h100] = 32'hDEAD_BEEF;
        mem_model[12'h104] = 32'hCAFE_F00D;
        mem_model[12'h108] = 32'h0BAD_F00D;
        mem_model[12'h10C] = 32'h8BAD_F00D;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        check("rst_stall_f", bus.stall_f, 0);

        // Fetch latency: grant at cycle 0, mem_req at 1, if_ready at 2
        expect_done(1'b0, 32'h0050_0093, 1'b0);
        rst         = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 12'h004;
        @(negedge clk);
        check("lat_mem_req_c1",  bus.mem_req,  1);
        check("lat_mem_addr_c1", bus.mem_addr, 12'h004);
        check("lat_mem_we_c1",   bus.mem_we,   0);
        check("lat_ready_c1",    bus.if_ready, 0);
        check("lat_stall_f_c1",  bus.stall_f,  1);
        @(negedge clk);
        check("lat_ready_c2",    bus.if_ready, 1);
        check("lat_stall_f_c2",  bus.stall_f,  0);
        check("lat_mem_req_c2",  bus.mem_req,  0);
        bus.if_req = 1'b0;
        @(negedge clk);

        // Simultaneous requests: data first, fetch in the following IDLE
        expect_done(1'b1, 32'hDEAD_BEEF, 1'b0);
        expect_done(1'b0, 32'h0010_0113, 1'b0);
        fork
            do_data(1'b0, 12'h100, '0, 50);
            do_fetch(12'h008, 50);
        join
        @(negedge clk);

        // Starvation: three data grants, then fetch forced, then data again
        expect_done(1'b1, 32'hDEAD_BEEF, 1'b0);
        expect_done(1'b1, 32'hCAFE_F00D, 1'b0);
        expect_done(1'b1, 32'h0BAD_F00D, 1'b0);
        expect_done(1'b0, 32'h0020_0193, 1'b0);
        expect_done(1'b1, 32'h8BAD_F00D, 1'b0);
        fork
            begin
                do_data(1'b0, 12'h100, '0, 60);
                do_data(1'b0, 12'h104, '0, 60);
                do_data(1'b0, 12'h108, '0, 60);
                do_data(1'b0, 12'h10C, '0, 60);
            end
            do_fetch(12'h00C, 100);
        join
        @(negedge clk);

        // Store with a slow memory: d_rdata keeps the last load value
        ack_delay = 2;
        expect_done(1'b1, 32'h8BAD_F00D, 1'b0);
        fork
            do_data(1'b1, 12'h010, 32'h1234_5678, 50);
            begin
                @(negedge clk);
                check("st_mem_req",   bus.mem_req,   1);
                check("st_mem_we",    bus.mem_we,    1);
                check("st_mem_addr",  bus.mem_addr,  12'h010);
                check("st_mem_wdata", bus.mem_wdata, 32'h1234_5678);
                check("st_stall_m",   bus.stall_m,   1);
                @(negedge clk);
                check("st_mem_req_held", bus.mem_req, 1);
                check("st_ready_early",  bus.d_ready, 0);
            end
        join
        ack_delay = 0;
        @(negedge clk);

        // Load back the stored word
        expect_done(1'b1, 32'h1234_5678, 1'b0);
        do_data(1'b0, 12'h010, '0, 50);
        @(negedge clk);

        // Reset while BUSY_D with the ack withheld: no ready, then re-arbitrate
        ack_en      = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 12'h104;
        repeat (3) @(negedge clk);
        check("rb_busy_mem_req", bus.mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rb");
        @(negedge clk);
        check("rb_no_ready", bus.d_ready, 0);
        expect_done(1'b1, 32'hCAFE_F00D, 1'b0);
        ack_en = 1'b1;
        rst    = 1'b0;
        do_data(1'b0, 12'h104, '0, 50);
        @(negedge clk);

`ifdef ARB_TIMEOUT_EN
        // Timeout: fetch never acknowledged -> NOP, bus_err with if_ready
        ack_en = 1'b0;
        expect_done(1'b0, 32'h0000_0013, 1'b1);
        fork
            do_fetch(12'h020, 60);
            begin
                int n = 0;
                repeat (24) begin
                    @(negedge clk);
                    if (bus.mem_req === 1'b1) n++;
                end
                check("tmo_mem_req_cycles", n, 16);
            end
        join
        ack_en = 1'b1;
        @(negedge clk);
`endif

        // Every expectation must have been consumed
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
